// File: rtl/i2c_regfile_slave.sv
// I2C target with a NUM_REGS x 8 register file, pointer bursts and host port.
// Optional macro I2C_CLK_STRETCH_EN: hold scl low STRETCH_CYCLES per read byte.
module i2c_regfile_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50,
  parameter int NUM_REGS = 16,
  parameter int FILTER_LEN = 3,
  parameter int STRETCH_CYCLES = 8,
  localparam int PTR_W = $clog2(NUM_REGS)
) (
  input  logic             clk,
  input  logic             rst,
  inout  wire              sda,
  inout  wire              scl,
  input  logic             host_we,
  input  logic [PTR_W-1:0] host_addr,
  input  logic [7:0]       host_wdata,
  output logic [7:0]       host_rdata,
  output logic             bus_wr_strobe,
  output logic [PTR_W-1:0] bus_wr_addr,
  output logic [7:0]       bus_wr_data,
  output logic             busy
);

  localparam int FCW = $clog2(FILTER_LEN + 1);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK,
    WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
  } state_t;

  state_t           state, state_n;
  logic [1:0]       m1, m2, flt, flt_q;
  logic [FCW-1:0]   fcnt [2];
  logic [7:0]       regs [NUM_REGS];
  logic [7:0]       shift, shift_n;
  logic [2:0]       bcnt, bcnt_n;
  logic [PTR_W-1:0] ptr, ptr_n, ptr_inc;
  logic             sda_oe, oe_n, busy_n;
  logic             rw, rw_n, ack9, ack9_n;
  logic             bus_we;
  logic             scl_rise, scl_fall;
  logic             start, stop, last;
  logic [7:0]       byte_in, rd_byte;

  // Bit 0 carries scl, bit 1 carries sda.
  // Synchronise both lines and only accept a level after FILTER_LEN samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      m1 <= 2'b11;
      m2 <= 2'b11;
      flt <= 2'b11;
      flt_q <= 2'b11;
      fcnt[0] <= '0;
      fcnt[1] <= '0;
    end else begin
      m1 <= {sda, scl};
      m2 <= m1;
      flt_q <= flt;
      for (int i = 0; i < 2; i++) begin
        if (m2[i] == flt[i]) begin
          fcnt[i] <= '0;
        end else if (fcnt[i] == FCW'(FILTER_LEN - 1)) begin
          flt[i] <= m2[i];
          fcnt[i] <= '0;
        end else begin
          fcnt[i] <= fcnt[i] + 1'b1;
        end
      end
    end
  end

  assign scl_rise = flt[0] & ~flt_q[0];
  assign scl_fall = ~flt[0] & flt_q[0];
  assign start = flt[0] & flt_q[0] & flt_q[1] & ~flt[1];
  assign stop = flt[0] & flt_q[0] & ~flt_q[1] & flt[1];
  assign last = (bcnt == 3'd7);
  assign byte_in = {shift[6:0], flt[1]};
  assign rd_byte = regs[ptr];
  assign ptr_inc = (ptr == PTR_W'(NUM_REGS - 1)) ? '0 : ptr + 1'b1;

  // Next-state and datapath decode; ack9 marks that the 9th rise has passed.
  always_comb begin
    state_n = state;
    shift_n = shift;
    bcnt_n = bcnt;
    ptr_n = ptr;
    oe_n = sda_oe;
    busy_n = busy;
    rw_n = rw;
    ack9_n = ack9;
    bus_we = 1'b0;
    if (stop) begin
      state_n = IDLE;
      oe_n = 1'b0;
      busy_n = 1'b0;
    end else if (start) begin
      state_n = ADDR;
      bcnt_n = '0;
      oe_n = 1'b0;
    end else begin
      unique case (state)
        ADDR: if (scl_rise) begin
          shift_n = byte_in;
          bcnt_n = bcnt + 3'd1;
          if (last) begin
            ack9_n = 1'b0;
            rw_n = flt[1];
            if (byte_in[7:1] == SLAVE_ADDR) begin
              state_n = ADDR_ACK;
              busy_n = 1'b1;
            end else begin
              state_n = IGNORE;
              busy_n = 1'b0;
            end
          end
        end
        PTR: if (scl_rise) begin
          shift_n = byte_in;
          bcnt_n = bcnt + 3'd1;
          if (last) begin
            ack9_n = 1'b0;
            if ({1'b0, byte_in} < 9'(NUM_REGS)) begin
              ptr_n = byte_in[PTR_W-1:0];
              state_n = PTR_ACK;
            end else begin
              state_n = IGNORE;
            end
          end
        end
        WDATA: if (scl_rise) begin
          shift_n = byte_in;
          bcnt_n = bcnt + 3'd1;
          if (last) begin
            ack9_n = 1'b0;
            bus_we = 1'b1;
            ptr_n = ptr_inc;
            state_n = WDATA_ACK;
          end
        end
        ADDR_ACK, PTR_ACK, WDATA_ACK: begin
          if (scl_rise) ack9_n = 1'b1;
          if (scl_fall && !ack9) oe_n = 1'b1;
          if (scl_fall && ack9) begin
            oe_n = 1'b0;
            bcnt_n = '0;
            if (state == ADDR_ACK && rw) begin
              shift_n = rd_byte;
              oe_n = ~rd_byte[7];
              state_n = RDATA;
            end else if (state == ADDR_ACK) begin
              state_n = PTR;
            end else begin
              state_n = WDATA;
            end
          end
        end
        RDATA: begin
          if (scl_rise) begin
            bcnt_n = bcnt + 3'd1;
            if (last) begin
              state_n = RDATA_ACK;
              ack9_n = 1'b0;
            end
          end
          if (scl_fall) begin
            shift_n = {shift[6:0], 1'b0};
            oe_n = ~shift[6];
          end
        end
        RDATA_ACK: begin
          if (scl_fall && !ack9) oe_n = 1'b0;
          if (scl_rise) begin
            ptr_n = ptr_inc;
            if (flt[1]) state_n = IGNORE;
            else ack9_n = 1'b1;
          end
          if (scl_fall && ack9) begin
            shift_n = rd_byte;
            oe_n = ~rd_byte[7];
            bcnt_n = '0;
            state_n = RDATA;
          end
        end
        default: ;
      endcase
    end
  end

  // State and transfer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      shift <= '0;
      bcnt <= '0;
      ptr <= '0;
      sda_oe <= 1'b0;
      busy <= 1'b0;
      rw <= 1'b0;
      ack9 <= 1'b0;
    end else begin
      state <= state_n;
      shift <= shift_n;
      bcnt <= bcnt_n;
      ptr <= ptr_n;
      sda_oe <= oe_n;
      busy <= busy_n;
      rw <= rw_n;
      ack9 <= ack9_n;
    end
  end

  // Register file: a bus write beats a host write to the same index.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      host_rdata <= '0;
      bus_wr_strobe <= 1'b0;
      bus_wr_addr <= '0;
      bus_wr_data <= '0;
    end else begin
      if (host_we && !(bus_we && host_addr == ptr))
        regs[host_addr] <= host_wdata;
      if (bus_we) regs[ptr] <= byte_in;
      host_rdata <= regs[host_addr];
      bus_wr_strobe <= bus_we;
      if (bus_we) begin
        bus_wr_addr <= ptr;
        bus_wr_data <= byte_in;
      end
    end
  end

  assign sda = (sda_oe && !rst) ? 1'b0 : 1'bz;

`ifdef I2C_CLK_STRETCH_EN
  localparam int SCW = $clog2(STRETCH_CYCLES + 1);
  logic [SCW-1:0] scnt;

  // Hold scl low for a fixed count whenever a read byte is fetched.
  always_ff @(posedge clk) begin
    if (rst) scnt <= '0;
    else if (state_n == RDATA && state != RDATA)
      scnt <= SCW'(STRETCH_CYCLES);
    else if (scnt != '0) scnt <= scnt - 1'b1;
  end

  assign scl = (scnt != '0 && !rst) ? 1'b0 : 1'bz;
`else
  assign scl = 1'bz;
`endif

endmodule
